preempt_timer: RTL



---
 rtl/preempt_timer_pkg.sv | 26 ++
 rtl/preempt_timer_if.sv | 34 +++
 rtl/preempt_timer_rr_next_sel.sv | 29 ++
 rtl/preempt_timer.sv | 118 +++++++++++
 4 files changed

// File: rtl/preempt_timer_pkg.sv
// Shared definitions for the preemptive context-switch timer:
// command encodings, FSM states and slot-index width derivation.
package preempt_pkg;

    typedef enum logic [2:0] {
        CMD_NOP         = 3'b000,
        CMD_SET_QUANTUM = 3'b001,
        CMD_READ_PC     = 3'b010,
        CMD_SET_PC      = 3'b011,
        CMD_START       = 3'b100,
        CMD_STOP        = 3'b101,
        CMD_ACK         = 3'b110,
        CMD_KILL        = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HANDLER = 2'd2
    } state_e;

    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/preempt_timer_if.sv
// CPU-side bundle of the preempt timer: command/data inputs and
// the PC-mux / status outputs.
interface preempt_timer_if
    import preempt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NPROC = 4,
    parameter int CNT_W = 16
) ();
    localparam int IDW = idw_f(NPROC);

    logic             halt;
    logic [WIDTH-1:0] pc_in;
    cmd_e             cmd;
    logic [IDW-1:0]   sel;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] vector_addr;
    logic             finish;
    logic [CNT_W-1:0] count;
    logic [IDW-1:0]   cur_id;
    logic             running;
    logic             in_handler;

    modport slave (
        input  halt, pc_in, cmd, sel, wdata,
        output rdata, vector_addr, finish, count, cur_id, running, in_handler
    );

    modport master (
        output halt, pc_in, cmd, sel, wdata,
        input  rdata, vector_addr, finish, count, cur_id, running, in_handler
    );
endinterface

// File: rtl/preempt_timer_rr_next_sel.sv
// Circular priority search over the active mask, starting one past cur_id.
// Falls back to cur_id when no other slot is active.
module rr_next_sel
    import preempt_pkg::*;
#(
    parameter int NPROC = 4,
    parameter int IDW   = idw_f(NPROC)
) (
    input  logic [NPROC-1:0] active,
    input  logic [IDW-1:0]   cur_id,
    output logic [IDW-1:0]   next_id
);
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        next_id = cur_id;
        found   = 1'b0;
        idx     = '0;
        // NPROC is a power of two, so the index add wraps naturally
        for (int i = 1; i < NPROC; i++) begin
            idx = cur_id + IDW'(i);
            if (!found && active[idx]) begin
                next_id = idx;
                found   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/preempt_timer.sv
// Preemptive round-robin context-switch timer: per-slot PC/quantum/active
// registers, a countdown that strobes finish on expiry, and a handler handshake.
module preempt_timer
    import preempt_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int NPROC           = 4,
    parameter int CNT_W           = 16,
    parameter int DEFAULT_QUANTUM = 100,
    parameter int HANDLER_ADDR    = 151
) (
    input  logic            clk,
    input  logic            reset,
    preempt_timer_if.slave  bus
);
    localparam int IDW = idw_f(NPROC);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [IDW-1:0]               cur_id_q, cur_id_d, next_id;
    logic [NPROC-1:0][WIDTH-1:0]  saved_pc_q, saved_pc_d;
    logic [NPROC-1:0][CNT_W-1:0]  quantum_q, quantum_d;
    logic [NPROC-1:0]             active_q, active_d;
    logic                         expire;

    rr_next_sel #(.NPROC(NPROC), .IDW(IDW)) u_rr (
        .active  (active_q),
        .cur_id  (cur_id_q),
        .next_id (next_id)
    );

    // STOP in the same cycle suppresses expiry; quantum 0 never expires
    assign expire = (state_q == ST_RUN) && !bus.halt && (count_q == CNT_W'(1)) &&
                    (quantum_q[cur_id_q] != '0) && (bus.cmd != CMD_STOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!bus.halt) begin
            case (state_q)
                ST_IDLE:    if (bus.cmd == CMD_START) state_d = ST_RUN;
                ST_RUN:     if (bus.cmd == CMD_STOP)  state_d = ST_IDLE;
                            else if (expire)          state_d = ST_HANDLER;
                ST_HANDLER: if (bus.cmd == CMD_STOP)  state_d = ST_IDLE;
                            else if (bus.cmd == CMD_ACK) state_d = ST_RUN;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.finish      = expire;
        bus.running     = (state_q == ST_RUN);
        bus.in_handler  = (state_q == ST_HANDLER);
        bus.rdata       = saved_pc_q[bus.sel];
        bus.vector_addr = WIDTH'(HANDLER_ADDR);
        bus.count       = count_q;
        bus.cur_id      = cur_id_q;
    end

    always_comb begin
        count_d    = count_q;
        cur_id_d   = cur_id_q;
        saved_pc_d = saved_pc_q;
        quantum_d  = quantum_q;
        active_d   = active_q;
        if (!bus.halt) begin
            case (bus.cmd)
                CMD_SET_QUANTUM: quantum_d[bus.sel] = bus.wdata[CNT_W-1:0];
                CMD_SET_PC: begin
                    saved_pc_d[bus.sel] = bus.wdata;
                    active_d[bus.sel]   = 1'b1;
                end
                CMD_KILL:        active_d[bus.sel] = 1'b0;
                default: ;
            endcase
            case (state_q)
                ST_IDLE: if (bus.cmd == CMD_START) begin
                    cur_id_d = bus.sel;
                    count_d  = quantum_q[bus.sel];
                end
                ST_RUN: if (bus.cmd == CMD_STOP) begin
                    count_d = '0;
                end else begin
                    if (count_q != '0) count_d = count_q - CNT_W'(1);
                    // capture after the SET_PC write so the live PC wins
                    if (expire) begin
                        saved_pc_d[cur_id_q] = bus.pc_in;
                        cur_id_d             = next_id;
                    end
                end
                ST_HANDLER: if (bus.cmd == CMD_STOP) count_d = '0;
                            else if (bus.cmd == CMD_ACK) count_d = quantum_q[cur_id_q];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            cur_id_q   <= '0;
            saved_pc_q <= '0;
            quantum_q  <= {NPROC{CNT_W'(DEFAULT_QUANTUM)}};
            active_q   <= NPROC'(1);
        end else begin
            count_q    <= count_d;
            cur_id_q   <= cur_id_d;
            saved_pc_q <= saved_pc_d;
            quantum_q  <= quantum_d;
            active_q   <= active_d;
        end
    end
endmodule
